fetch_sequencer: RTL

Control-side sequencer for the 4-bit CPU datapath. It drives the fetch unit's program-counter and fetch-register controls (EN1, EN2, LD, INP), and consumes the fetched INSTR/OPRND nibbles and the program byte PB. It decodes jumps and halt, and issues a one-cycle execute strobe for every other opcode. It sits between the fetch unit and the ALU/accumulator block.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_sequencer_jump_cond.sv | 37 +++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: opcodes, FSM states, PC width.
package fetch_pkg;

  localparam int PC_W = 12;

  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_sequencer_jump_cond.sv
// Combinational jump decision: flags a conditional-jump opcode and whether
// the current opcode transfers control (JMP always, JC/JZ on their flag).
module jump_cond
  import fetch_pkg::*;
(
  input  logic [3:0] instr,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       is_cond,
  output logic       taken
);

  // Decode the opcode into conditional/taken indications
  always_comb begin
    is_cond = 1'b0;
    taken   = 1'b0;
    case (instr)
      OP_JMP: begin
        is_cond = 1'b0;
        taken   = 1'b1;
      end
      OP_JC: begin
        is_cond = 1'b1;
        taken   = c_flag;
      end
      OP_JZ: begin
        is_cond = 1'b1;
        taken   = z_flag;
      end
      default: begin
        is_cond = 1'b0;
        taken   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Control sequencer for the 4-bit CPU: drives PC/fetch-register strobes,
// resolves jumps and halt, issues exec and counts retired instructions.
// Optional single-step input enabled by macro FETCH_SEQUENCER_STEP_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int CNT_W = 8
) (
`ifdef FETCH_SEQUENCER_STEP_EN
  input  logic             step,
`endif
  input  logic             clck,
  input  logic             rst,
  input  logic             run,
  input  logic             c_flag,
  input  logic             z_flag,
  input  logic [3:0]       INSTR,
  input  logic [3:0]       OPRND,
  input  logic [7:0]       PB,
  output logic             EN1,
  output logic             EN2,
  output logic             LD,
  output logic [PC_W-1:0]  INP,
  output logic             exec,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  logic   is_cond;
  logic   taken;
  logic   start;

  jump_cond u_jump_cond (
    .instr   (INSTR),
    .c_flag  (c_flag),
    .z_flag  (z_flag),
    .is_cond (is_cond),
    .taken   (taken)
  );

`ifdef FETCH_SEQUENCER_STEP_EN
  logic step_prev;

  // Remember last step level so a held step launches only one instruction
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      step_prev <= 1'b0;
    end else begin
      step_prev <= step;
    end
  end

  assign start = run | (step & ~step_prev);
`else
  assign start = run;
`endif

  // State sequencing and retired-instruction counter
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      retired <= {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        FETCH: begin
          state <= DECODE;
        end
        DECODE: begin
          if (INSTR == OP_HALT) begin
            state <= HALT;
          end else begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            state   <= run ? FETCH : IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobe decode from current state and fetched instruction
  always_comb begin
    EN1    = 1'b0;
    EN2    = 1'b0;
    LD     = 1'b0;
    INP    = {PC_W{1'b0}};
    exec   = 1'b0;
    halted = 1'b0;
    case (state)
      IDLE: begin
        halted = 1'b0;
      end
      FETCH: begin
        EN1 = 1'b1;
        EN2 = 1'b1;
      end
      DECODE: begin
        if (INSTR == OP_HALT) begin
          halted = 1'b0;
        end else if (taken) begin
          LD  = 1'b1;
          INP = {OPRND, PB};
        end else if (is_cond) begin
          // Untaken branch: step the PC over the address byte
          EN1 = 1'b1;
        end else begin
          exec = 1'b1;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule
